ex_mem_pipe_reg: RTL and testbench

EX_MEM_PIPE_REG -- requirements
Module: ex_mem_pipe_reg

---
 rtl/ex_mem_pipe_reg.sv | 91 +++++++++
 tb/tb_ex_mem_pipe_reg.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with valid/ready handshake, store-data forwarding mux and flush.
// Optional stall counter output enabled by defining EXMEM_STALL_CNT_EN.
module ex_mem_pipe_reg #(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int CTRL_W   = 27,
  parameter int RFWR_BIT = 23,
  parameter int DMWR_BIT = 22,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [1:0]        fwd_sel,
  input  logic [DATA_W-1:0] fwd_rf,
  input  logic [DATA_W-1:0] fwd_alu,
  input  logic [DATA_W-1:0] fwd_mem,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_out,
  output logic [REG_W-1:0]  rd_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] store_data,
  output logic              rf_wr,
  output logic              dm_wr
`ifdef EXMEM_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  logic              capture;
  logic              drain;
  logic [DATA_W-1:0] storeSel;

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;
  assign drain    = out_valid && out_ready;

  always_comb begin
    storeSel = fwd_rf;
    case (fwd_sel)
      2'b01:   storeSel = fwd_alu;
      2'b10:   storeSel = fwd_mem;
      default: storeSel = fwd_rf;
    endcase
  end

  // Flush wins over capture and drain; payload is only ever written on capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_out    <= '0;
      rd_out     <= '0;
      ctrl_out   <= '0;
      store_data <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid  <= 1'b1;
      alu_out    <= alu_in;
      rd_out     <= rd_in;
      ctrl_out   <= ctrl_in;
      store_data <= storeSel;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  assign rf_wr = out_valid && ctrl_out[RFWR_BIT];
  assign dm_wr = out_valid && ctrl_out[DMWR_BIT];

`ifdef EXMEM_STALL_CNT_EN
  logic stallEdge;
  assign stallEdge = out_valid && !out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stallEdge && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed self-checking bench for ex_mem_pipe_reg; stall counter checks run only
// when EXMEM_STALL_CNT_EN is defined (a second instance with CNT_W=2 covers saturation).
module tb_ex_mem_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] ctrl_in;
  logic [31:0] alu_in;
  logic [4:0]  rd_in;
  logic [1:0]  fwd_sel;
  logic [31:0] fwd_rf, fwd_alu, fwd_mem;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_out;
  logic [4:0]  rd_out;
  logic [26:0] ctrl_out;
  logic [31:0] store_data;
  logic        rf_wr, dm_wr;

  int nErr = 0;
  int nChecks = 0;

  always #5 clk = ~clk;

`ifdef EXMEM_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic        inReady2, outValid2, rfWr2, dmWr2;
  logic [31:0] aluOut2, storeData2;
  logic [4:0]  rdOut2;
  logic [26:0] ctrlOut2;
  logic [1:0]  stallCnt2;
`endif

  ex_mem_pipe_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(ctrl_in), .alu_in(alu_in), .rd_in(rd_in), .fwd_sel(fwd_sel),
    .fwd_rf(fwd_rf), .fwd_alu(fwd_alu), .fwd_mem(fwd_mem),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out), .rd_out(rd_out),
    .ctrl_out(ctrl_out), .store_data(store_data), .rf_wr(rf_wr), .dm_wr(dm_wr)
`ifdef EXMEM_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

`ifdef EXMEM_STALL_CNT_EN
  ex_mem_pipe_reg #(.CNT_W(2)) dutSat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(inReady2),
    .ctrl_in(ctrl_in), .alu_in(alu_in), .rd_in(rd_in), .fwd_sel(fwd_sel),
    .fwd_rf(fwd_rf), .fwd_alu(fwd_alu), .fwd_mem(fwd_mem),
    .out_valid(outValid2), .out_ready(out_ready), .alu_out(aluOut2), .rd_out(rdOut2),
    .ctrl_out(ctrlOut2), .store_data(storeData2), .rf_wr(rfWr2), .dm_wr(dmWr2),
    .stall_cnt(stallCnt2)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nErr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ctrl_in = '0; alu_in = '0; rd_in = '0; fwd_sel = 2'b00;
    fwd_rf = 32'hA; fwd_alu = 32'hB; fwd_mem = 32'hC;
    #3;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_rf_wr",     {31'b0, rf_wr},     32'd0);
    chk("rst_alu_out",   alu_out,            32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic capture with register-file write enable
    in_valid = 1'b1; alu_in = 32'h1234; rd_in = 5'd7; ctrl_in = 27'd1 << 23; out_ready = 1'b1;
    tick();
    chk("cap_out_valid", {31'b0, out_valid}, 32'd1);
    chk("cap_alu_out",   alu_out,            32'h1234);
    chk("cap_rd_out",    {27'b0, rd_out},    32'd7);
    chk("cap_rf_wr",     {31'b0, rf_wr},     32'd1);
    chk("cap_dm_wr",     {31'b0, dm_wr},     32'd0);
    chk("fwd_sel00",     store_data,         32'hA);

    // Forwarding selects on back-to-back captures
    fwd_sel = 2'b01; alu_in = 32'h2001;
    tick();
    chk("fwd_sel01",     store_data,         32'hB);
    chk("b2b_valid",     {31'b0, out_valid}, 32'd1);
    chk("b2b_alu",       alu_out,            32'h2001);
    fwd_sel = 2'b10; alu_in = 32'h2002;
    tick();
    chk("fwd_sel10",     store_data,         32'hC);
    fwd_sel = 2'b11; alu_in = 32'h2003;
    tick();
    chk("fwd_sel11",     store_data,         32'hA);

    // Drain with nothing new: valid drops, payload retained
    in_valid = 1'b0;
    tick();
    chk("drain_valid",   {31'b0, out_valid}, 32'd0);
    chk("drain_rf_wr",   {31'b0, rf_wr},     32'd0);
    chk("drain_alu_hold", alu_out,           32'h2003);

    // Fill, then stall three cycles with a new instruction waiting
    in_valid = 1'b1; alu_in = 32'h3333; rd_in = 5'd3; ctrl_in = '0; fwd_sel = 2'b01;
    tick();
    chk("fill_alu",      alu_out,            32'h3333);
    out_ready = 1'b0; alu_in = 32'h4444; rd_in = 5'd4; fwd_sel = 2'b10;
    #1;
    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_alu_frozen",   alu_out,            32'h3333);
      chk("stall_store_frozen", store_data,         32'hB);
      chk("stall_valid",        {31'b0, out_valid}, 32'd1);
    end
`ifdef EXMEM_STALL_CNT_EN
    chk("stall_cnt3",    {16'b0, stall_cnt}, 32'd3);
`endif
    out_ready = 1'b1;
    tick();
    chk("unstall_alu",   alu_out,            32'h4444);
    chk("unstall_rd",    {27'b0, rd_out},    32'd4);
    chk("unstall_store", store_data,         32'hC);
    chk("unstall_valid", {31'b0, out_valid}, 32'd1);

    // Store instruction then flush while stalled
    alu_in = 32'h5555; ctrl_in = 27'd1 << 22;
    tick();
    chk("st_dm_wr",      {31'b0, dm_wr},     32'd1);
    chk("st_rf_wr",      {31'b0, rf_wr},     32'd0);
    out_ready = 1'b0; flush = 1'b1; alu_in = 32'h6666;
    tick();
    chk("flush_valid",   {31'b0, out_valid}, 32'd0);
    chk("flush_dm_wr",   {31'b0, dm_wr},     32'd0);
    chk("flush_alu",     alu_out,            32'h5555);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef EXMEM_STALL_CNT_EN
    chk("flush_no_count", {16'b0, stall_cnt}, 32'd3);
`endif
    flush = 1'b0;

    // Capture, stall five cycles, then asynchronous reset between edges
    out_ready = 1'b1; alu_in = 32'h7777; ctrl_in = 27'd1 << 23;
    tick();
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b0; in_valid = 1'b0;
    repeat (5) tick();
`ifdef EXMEM_STALL_CNT_EN
    chk("stall_cnt8",    {16'b0, stall_cnt}, 32'd8);
    chk("sat_cnt",       {30'b0, stallCnt2}, 32'd3);
`endif
    #2 rst = 1'b1;
    #1;
    chk("arst_valid",    {31'b0, out_valid}, 32'd0);
    chk("arst_alu",      alu_out,            32'd0);
    chk("arst_store",    store_data,         32'd0);
    chk("arst_ctrl",     {5'b0, ctrl_out},   32'd0);
    chk("arst_rf_wr",    {31'b0, rf_wr},     32'd0);
    chk("arst_in_ready", {31'b0, in_ready},  32'd1);
`ifdef EXMEM_STALL_CNT_EN
    chk("arst_cnt",      {16'b0, stall_cnt}, 32'd0);
    chk("arst_sat_cnt",  {30'b0, stallCnt2}, 32'd0);
`endif
    #1 rst = 1'b0;

    in_valid = 1'b1; out_ready = 1'b1; alu_in = 32'h8888; rd_in = 5'd9; fwd_sel = 2'b00;
    tick();
    chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
    chk("post_rst_alu",   alu_out,            32'h8888);
    chk("post_rst_rd",    {27'b0, rd_out},    32'd9);

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
